cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups with a second-level group-carry lookahead. It accepts one operand pair per cycle over a valid/ready handshake, supports add and subtract per transaction, and returns the sum with carry, signed-overflow, zero and word-level propagate/generate flags. It is the general-width, registered replacement for the fixed 4-bit combinational lookahead adder, intended for datapaths that need backpressure and a predictable latency.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  block can accept a transaction this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in when sub=0; borrow-in when sub=1.
- sub  in  1  0: A+B+cin; 1: A−B−cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB (in subtract mode 1 means no borrow).
- ovf  out  1  two's-complement overflow.
- zero  out  1  sum == 0.
- pg  out  1  word propagate: AND of all bit propagates.
- gg  out  1  word generate: carry-out with the carry-in forced to 0.

## Operation
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. All flags are computed on a + b_eff + c0.
- Stage 1 (S1): on a transfer, registers a, b_eff and c0. Computes per-bit p = a^b_eff and g = a&b_eff. Computes per-group (4-bit) P and G.
- Stage 2 (S2): computes the group carries with a lookahead across the groups from c0. Computes in-group carries, then sum = p ^ carry. Registers sum, cout, ovf = carry_into_MSB ^ cout, zero, pg and gg.
- Outputs are driven directly from S2 registers; no combinational path runs from a/b to sum.
- Handshake:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load (combinational).
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Bubbles collapse: an empty stage always accepts. Throughput is one result per cycle when out_ready is held high.
- While out_valid && !out_ready, S2 holds all outputs stable. S1 holds its contents if it is full. in_ready drops once both stages are full.
- Order is preserved. Every accepted transaction produces exactly one result, with no loss or duplication.
- Simultaneous output transfer and S1→S2 load in one cycle: S2 takes the new data and out_valid stays 1.

## Timing
- Reset (asynchronous, effective immediately):
  - s1_valid = 0 and out_valid = 0.
  - sum, cout, ovf, zero, pg, gg = 0.
  - in_ready = 1 while rst is high and on the first cycle after it is released.
- Latency: a transaction accepted at clock edge k has out_valid = 1 after edge k+1, visible in the cycle following edge k+1 (2 registered stages). This assumes S2 is free at edge k+1.
- Reset mid-operation: all in-flight transactions are discarded. out_valid falls asynchronously with rst, and no partial result is ever presented.
- in_valid/a/b/cin/sub are sampled only on a transfer edge. Changes while in_ready = 0 are ignored.
- Wrap-around: sum is truncated to WIDTH bits. Overflow is reported only via cout/ovf.

## Test plan
- Reset, then add a=0x00FF, b=0x0001, cin=0 -> two cycles later: sum=0x0100, cout=0, ovf=0, zero=0, gg=0.
- Add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, pg=0, gg=1. Then add a=0xAAAA, b=0x5555, cin=1 -> sum=0x0000, cout=1, pg=1, gg=0.
- Subtract a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Subtract a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Add a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0. Repeat at WIDTH=4 and WIDTH=32 with equivalent corner values.
- Stream 4 back-to-back transactions with out_ready=0 for 3 cycles:
  - in_ready falls after 2 transactions are accepted.
  - sum stays stable while stalled.
  - After out_ready rises, all 4 results arrive in order on consecutive cycles.
- Assert rst while out_valid=1 and S1 is full -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// S1 registers the effective operands; S2 resolves group and in-group carries
// and registers the sum plus word-level flags. Valid/ready handshake on both sides.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             pg,
  output logic             gg
);

  localparam int NG = int'(WIDTH) / 4;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  // Stage 1 state
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_c0_q;

  // Stage 2 state
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q, pg_q, gg_q;

  logic s2_load;
  logic in_xfer;

  // Stage 2 can take S1 whenever it is empty or being drained this cycle
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_xfer  = in_valid && in_ready;

  // S1 register: capture subtract-adjusted operands on an input transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c0_q    <= 1'b0;
    end else if (in_xfer) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= a;
      s1_b_q     <= sub ? ~b : b;
      s1_c0_q    <= sub ? ~cin : cin;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  logic [WIDTH-1:0] p, g;
  logic [NG-1:0]    grp_p, grp_g;

  assign p = s1_a_q ^ s1_b_q;
  assign g = s1_a_q & s1_b_q;

  // 4-bit group propagate/generate
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < NG; j++) begin
      grp_p[j] = &p[4*j +: 4];
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
  end

  logic [NG:0] gcarry;
  logic        word_g;
  logic        grun;

  // Second-level lookahead: each group carry as a flat sum of products over lower groups
  always_comb begin
    gcarry = '0;
    word_g = 1'b0;
    grun   = 1'b0;
    for (int j = 0; j <= NG; j++) begin
      grun = 1'b1;
      for (int k = j - 1; k >= 0; k--) begin
        gcarry[j] = gcarry[j] | (grun & grp_g[k]);
        grun      = grun & grp_p[k];
      end
      gcarry[j] = gcarry[j] | (grun & s1_c0_q);
    end
    // Word generate is the same top-level expansion with the carry-in forced low
    grun = 1'b1;
    for (int k = NG - 1; k >= 0; k--) begin
      word_g = word_g | (grun & grp_g[k]);
      grun   = grun & grp_p[k];
    end
  end

  logic [WIDTH:0] carry;
  logic           brun;

  // In-group lookahead from each group's carry-in; carry[i] is the carry into bit i
  always_comb begin
    carry = '0;
    brun  = 1'b0;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < 4; i++) begin
        brun = 1'b1;
        for (int k = i - 1; k >= 0; k--) begin
          carry[4*j+i] = carry[4*j+i] | (brun & g[4*j+k]);
          brun         = brun & p[4*j+k];
        end
        carry[4*j+i] = carry[4*j+i] | (brun & gcarry[j]);
      end
    end
    carry[WIDTH] = gcarry[NG];
  end

  logic [WIDTH-1:0] sum_d;
  assign sum_d = p ^ carry[WIDTH-1:0];

  // S2 register: load from S1, or retire the held result on an output transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      pg_q        <= 1'b0;
      gg_q        <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= 1'b1;
      sum_q       <= sum_d;
      cout_q      <= carry[WIDTH];
      ovf_q       <= carry[WIDTH-1] ^ carry[WIDTH];
      zero_q      <= (sum_d == '0);
      pg_q        <= &p;
      gg_q        <= word_g;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign pg        = pg_q;
  assign gg        = gg_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder at WIDTH 16, 4 and 32 driven in lockstep.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, out_ready, cin, sub;
  logic [15:0] a16, b16, sum16;
  logic [3:0]  a4, b4, sum4;
  logic [31:0] a32, b32, sum32;
  logic ir16, ov16, co16, of16, zr16, pg16, gg16;
  logic ir4, ov4, co4, of4, zr4, pg4, gg4;
  logic ir32, ov32, co32, of32, zr32, pg32, gg32;

  cla_pipe_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .sum(sum16),
    .cout(co16), .ovf(of16), .zero(zr16), .pg(pg16), .gg(gg16)
  );
  cla_pipe_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(out_ready), .sum(sum4),
    .cout(co4), .ovf(of4), .zero(zr4), .pg(pg4), .gg(gg4)
  );
  cla_pipe_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .sum(sum32),
    .cout(co32), .ovf(of32), .zero(zr32), .pg(pg32), .gg(gg32)
  );

  // {cout, ovf, zero, pg, gg, sum zero-extended to 32 bits}
  typedef logic [36:0] res_t;

  res_t o16, o4, o32;
  assign o16 = {co16, of16, zr16, pg16, gg16, 16'b0, sum16};
  assign o4  = {co4, of4, zr4, pg4, gg4, 28'b0, sum4};
  assign o32 = {co32, of32, zr32, pg32, gg32, sum32};

  int total = 0;
  int bad   = 0;
  res_t q16[$], q4[$], q32[$];
  logic in_xfer, out_xfer;

  // Reference: plain integer arithmetic on the effective operands
  function automatic res_t model(int w, logic [31:0] x, logic [31:0] y, logic ci,
                                 logic is_sub);
    longint mask, ua, ub, beff, c0, tot, lim, sa, sbv, r;
    logic co, ov, zr, wp, wg;
    logic [31:0] s;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(x) & mask;
    ub   = longint'(y) & mask;
    beff = is_sub ? (~ub & mask) : ub;
    c0   = (is_sub ^ ci) ? 1 : 0;
    tot  = ua + beff + c0;
    s    = 32'(tot & mask);
    co   = ((tot >> w) & 1) != 0;
    lim  = longint'(1) << (w - 1);
    sa   = (ua >= lim) ? ua - (mask + 1) : ua;
    sbv  = (ub >= lim) ? ub - (mask + 1) : ub;
    r    = is_sub ? sa - sbv - longint'(ci) : sa + sbv + longint'(ci);
    ov   = (r >= lim) || (r < -lim);
    zr   = (s == 0);
    wp   = ((ua ^ beff) == mask);
    wg   = (((ua + beff) >> w) & 1) != 0;
    return {co, ov, zr, wp, wg, s};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settle, score outputs against the queues, book transfers, advance one cycle
  task automatic tick();
    #1;
    if (ov16) begin
      check("r16_pending", 64'(q16.size() != 0), 64'(1));
      if (q16.size() != 0) check("r16", o16, q16[0]);
    end
    if (ov4) begin
      check("r4_pending", 64'(q4.size() != 0), 64'(1));
      if (q4.size() != 0) check("r4", o4, q4[0]);
    end
    if (ov32) begin
      check("r32_pending", 64'(q32.size() != 0), 64'(1));
      if (q32.size() != 0) check("r32", o32, q32[0]);
    end
    out_xfer = ov16 && out_ready;
    in_xfer  = in_valid && ir16;
    if (ov16 && out_ready && q16.size() != 0) void'(q16.pop_front());
    if (ov4 && out_ready && q4.size() != 0) void'(q4.pop_front());
    if (ov32 && out_ready && q32.size() != 0) void'(q32.pop_front());
    if (in_valid && ir16) q16.push_back(model(16, 32'(a16), 32'(b16), cin, sub));
    if (in_valid && ir4) q4.push_back(model(4, 32'(a4), 32'(b4), cin, sub));
    if (in_valid && ir32) q32.push_back(model(32, a32, b32, cin, sub));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randomize_ops();
    a16 = 16'($urandom); b16 = 16'($urandom);
    a4  = 4'($urandom);  b4  = 4'($urandom);
    a32 = $urandom;      b32 = $urandom;
    cin = 1'($urandom);  sub = 1'($urandom);
  endtask

  typedef struct {
    logic [15:0] a16, b16;
    logic [3:0]  a4, b4;
    logic [31:0] a32, b32;
    logic        ci, sb;
    res_t        lit;
  } vec_t;

  vec_t dv[6];
  int   sent;
  logic [15:0] held;

  initial begin
    dv[0] = '{16'h00FF, 16'h0001, 4'h3, 4'h1, 32'h0000FFFF, 32'h1, 1'b0, 1'b0,
              {5'b00000, 32'h0100}};
    dv[1] = '{16'hFFFF, 16'h0001, 4'hF, 4'h1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0,
              {5'b10101, 32'h0000}};
    dv[2] = '{16'hAAAA, 16'h5555, 4'hA, 4'h5, 32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0,
              {5'b10110, 32'h0000}};
    dv[3] = '{16'h0005, 16'h0007, 4'h5, 4'h7, 32'h5, 32'h7, 1'b0, 1'b1,
              {5'b00000, 32'hFFFE}};
    dv[4] = '{16'h8000, 16'h0001, 4'h8, 4'h1, 32'h80000000, 32'h1, 1'b0, 1'b1,
              {5'b11001, 32'h7FFF}};
    dv[5] = '{16'h7FFF, 16'h0001, 4'h7, 4'h1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0,
              {5'b01000, 32'h8000}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    a16 = '0; b16 = '0; a4 = '0; b4 = '0; a32 = '0; b32 = '0;
    in_xfer = 1'b0; out_xfer = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_in_ready", 64'(ir16), 64'(1));
    check("rst_out_valid", 64'({ov16, ov4, ov32}), 64'(0));
    check("rst_outputs16", o16, 64'(0));
    check("rst_outputs32", o32, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(ir16), 64'(1));

    // Directed corner vectors, one at a time, with latency checks
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a16 = dv[i].a16; b16 = dv[i].b16; a4 = dv[i].a4; b4 = dv[i].b4;
      a32 = dv[i].a32; b32 = dv[i].b32; cin = dv[i].ci; sub = dv[i].sb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("lat_early%0d", i), 64'(ov16), 64'(0));
      tick();
      check($sformatf("lat_valid%0d", i), 64'(ov16), 64'(1));
      check($sformatf("lit%0d", i), o16, dv[i].lit);
      tick();
    end

    // Back-to-back stream with a 3-cycle output stall
    sent = 0;
    held = '0;
    for (int c = 0; c < 10; c++) begin
      randomize_ops();
      in_valid  = (sent < 4);
      out_ready = (c >= 5);
      #1;
      check($sformatf("strm_in_ready%0d", c), 64'(ir16), 64'(!(c >= 2 && c <= 4)));
      check($sformatf("strm_out_valid%0d", c), 64'(ov16), 64'(c >= 2 && c <= 8));
      if (c == 2) held = sum16;
      if (c == 4) check("strm_stall_sum", 64'(sum16), 64'(held));
      tick();
      if (in_xfer) sent++;
    end
    in_valid = 1'b0;
    check("strm_sent", 64'(sent), 64'(4));
    check("strm_drained", 64'(q16.size()), 64'(0));

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      randomize_ops();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("rand_drain16", 64'(q16.size()), 64'(0));
    check("rand_drain4", 64'(q4.size()), 64'(0));
    check("rand_drain32", 64'(q32.size()), 64'(0));

    // Reset with both stages full
    out_ready = 1'b0;
    randomize_ops();
    in_valid = 1'b1;
    tick();
    randomize_ops();
    tick();
    in_valid = 1'b0;
    #1;
    check("full_out_valid", 64'(ov16), 64'(1));
    check("full_in_ready", 64'(ir16), 64'(0));
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'({ov16, ov4, ov32}), 64'(0));
    check("midrst_outputs16", o16, 64'(0));
    check("midrst_outputs4", o4, 64'(0));
    check("midrst_in_ready", 64'(ir16), 64'(1));
    q16.delete(); q4.delete(); q32.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rel_in_ready", 64'(ir16), 64'(1));
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("no_stale%0d", c), 64'(ov16), 64'(0));
    end
    randomize_ops();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("final_drain16", 64'(q16.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
